// File: rtl/pack_n_m_if.sv
// Purpose: the serial word stream in and the m-word parallel frame out for pack_n_m.
// Latency: wiring only.
// Backpressure: ready_o gates the serial side; fl_end holds until ack_i.
//
// Ports:
//   flush_i  drop a partial frame        data_i/valid_i/ready_o  serial handshake
//   ack_i    consumer took the frame     data_o/cnt_o/fl_end     parallel frame side
// master = the side that drives the stream and acks frames.
// slave  = the packer itself.
interface pack_n_m_if #(
  parameter int n = 32,
  parameter int m = 4
);
  localparam int cw = $clog2(m) + 1;

  logic          flush_i;
  logic [n-1:0]  data_i;
  logic          valid_i;
  logic          ready_o;
  logic          ack_i;
  logic [n-1:0]  data_o [0:m-1];
  logic [cw-1:0] cnt_o;
  logic          fl_end;

  modport master (
    output flush_i, data_i, valid_i, ack_i,
    input  ready_o, data_o, cnt_o, fl_end
  );

  modport slave (
    input  flush_i, data_i, valid_i, ack_i,
    output ready_o, data_o, cnt_o, fl_end
  );
endinterface

// File: rtl/pack_n_m.sv
// Purpose: serial-to-parallel packer, m words of n bits assembled into one frame.
// Latency: fl_end rises 1 cycle after the m-th transfer edge; m+1 cycles per frame with ack_i held high.
// Backpressure: ready_o drops for the whole FULL state; the frame is held until ack_i.
//
// Ports:
//   clk_i  rising-edge clock       rst_i  synchronous active-high reset
//   pk     pack_n_m_if slave side: stream in (data_i/valid_i/ready_o), flush_i,
//          frame out (data_o/cnt_o/fl_end), release (ack_i)
module pack_n_m #(
  parameter int n = 32,
  parameter int m = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  pack_n_m_if.slave     pk
);
  localparam int cw = $clog2(m) + 1;
  localparam logic [cw-1:0] last_idx = cw'(m - 1);

  typedef enum logic {FILL, FULL} state_t;

  state_t        state_q, state_d;
  logic [cw-1:0] cnt_q, cnt_d;
  logic          wr_en;
  logic [n-1:0]  data_q [0:m-1];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= FILL;
      cnt_q   <= '0;
      for (int i = 0; i < m; i++) data_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      // wr_en only fires in FILL, where cnt_q < m, so the slot always exists.
      for (int i = 0; i < m; i++) begin
        if (wr_en && cnt_q == cw'(i)) data_q[i] <= pk.data_i;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    unique case (state_q)
      FILL: begin
        // flush beats a coincident transfer; stale data_o entries are left in place.
        if (pk.flush_i) begin
          cnt_d = '0;
        end else if (pk.valid_i) begin
          wr_en = 1'b1;
          cnt_d = cnt_q + cw'(1);
          if (cnt_q == last_idx) state_d = FULL;
        end
      end
      FULL: begin
        // ready_o is low here, so nothing presented in the ack cycle is taken.
        if (pk.ack_i) begin
          state_d = FILL;
          cnt_d   = '0;
        end
      end
      default: state_d = FILL;
    endcase
  end

  assign pk.ready_o = (state_q == FILL);
  assign pk.fl_end  = (state_q == FULL);
  assign pk.cnt_o   = cnt_q;
  assign pk.data_o  = data_q;
endmodule

// File: tb/tb_pack_n_m.sv
// Purpose: directed self-checking bench for pack_n_m (n=32, m=4).
// Latency: drives inputs and samples outputs 1 time unit after each rising edge.
// Backpressure: the stream driver holds its word while ready_o is low.
module tb_pack_n_m;
  localparam int n = 32;
  localparam int m = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  pack_n_m_if #(.n(n), .m(m)) bus ();

  pack_n_m #(.n(n), .m(m)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .pk    (bus)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_frame(input string tag, input logic [31:0] w0, input logic [31:0] w1,
                           input logic [31:0] w2, input logic [31:0] w3);
    chk({tag, "_d0"}, bus.data_o[0], w0);
    chk({tag, "_d1"}, bus.data_o[1], w1);
    chk({tag, "_d2"}, bus.data_o[2], w2);
    chk({tag, "_d3"}, bus.data_o[3], w3);
  endtask

  // One word on one cycle; the packer must be in FILL.
  task automatic send(input logic [31:0] w);
    bus.valid_i = 1'b1;
    bus.data_i  = w;
    tick();
    bus.valid_i = 1'b0;
  endtask

  task automatic release_frame();
    bus.ack_i = 1'b1;
    tick();
    bus.ack_i = 1'b0;
  endtask

  initial begin
    bus.flush_i = 1'b0;
    bus.data_i  = '0;
    bus.valid_i = 1'b0;
    bus.ack_i   = 1'b0;

    // Reset state
    tick();
    tick();
    rst = 1'b0;
    chk("rst_cnt", 32'(bus.cnt_o), 32'd0);
    chk("rst_fl_end", 32'(bus.fl_end), 32'd0);
    chk("rst_ready", 32'(bus.ready_o), 32'd1);
    chk_frame("rst", 0, 0, 0, 0);

    // 1: four back-to-back words
    for (int k = 1; k <= 4; k++) begin
      chk("t1_fl_end_before", 32'(bus.fl_end), 32'd0);
      send(32'(k));
      chk("t1_cnt", 32'(bus.cnt_o), 32'(k));
    end
    chk("t1_fl_end", 32'(bus.fl_end), 32'd1);
    chk("t1_ready", 32'(bus.ready_o), 32'd0);
    chk_frame("t1", 1, 2, 3, 4);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("t1_hold_fl_end", 32'(bus.fl_end), 32'd1);
      chk("t1_hold_cnt", 32'(bus.cnt_o), 32'd4);
      chk("t1_hold_d3", bus.data_o[3], 32'd4);
    end

    // 2: word held through the ack cycle, taken on the following edge
    bus.valid_i = 1'b1;
    bus.data_i  = 32'hAA;
    tick();
    chk("t2_no_take_full", bus.data_o[0], 32'd1);
    bus.ack_i = 1'b1;
    tick();
    bus.ack_i = 1'b0;
    chk("t2_fl_end", 32'(bus.fl_end), 32'd0);
    chk("t2_cnt", 32'(bus.cnt_o), 32'd0);
    chk("t2_ready", 32'(bus.ready_o), 32'd1);
    chk("t2_no_take_ack", bus.data_o[0], 32'd1);
    tick();
    bus.valid_i = 1'b0;
    chk("t2_d0", bus.data_o[0], 32'hAA);
    chk("t2_cnt1", 32'(bus.cnt_o), 32'd1);
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    chk("t2_flush_cnt", 32'(bus.cnt_o), 32'd0);

    // 3: gapped stream
    for (int k = 1; k <= 4; k++) begin
      send(32'(k * 16));
      chk("t3_cnt_step", 32'(bus.cnt_o), 32'(k));
      tick();
      tick();
      chk("t3_cnt_idle", 32'(bus.cnt_o), 32'(k));
    end
    chk("t3_fl_end", 32'(bus.fl_end), 32'd1);
    chk_frame("t3", 32'h10, 32'h20, 32'h30, 32'h40);
    release_frame();

    // 4: flush with a coincident word, then a clean frame
    send(5);
    send(6);
    bus.valid_i = 1'b1;
    bus.flush_i = 1'b1;
    bus.data_i  = 7;
    tick();
    bus.valid_i = 1'b0;
    bus.flush_i = 1'b0;
    chk("t4_flush_cnt", 32'(bus.cnt_o), 32'd0);
    chk("t4_d2_kept", bus.data_o[2], 32'h30);
    chk("t4_d1_kept", bus.data_o[1], 32'd6);
    for (int k = 8; k <= 11; k++) send(32'(k));
    chk("t4_fl_end", 32'(bus.fl_end), 32'd1);
    chk_frame("t4", 8, 9, 10, 11);
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    chk("t4_flush_full_ignored", 32'(bus.fl_end), 32'd1);
    chk("t4_flush_full_cnt", 32'(bus.cnt_o), 32'd4);
    bus.ack_i = 1'b1;
    tick();
    chk("t4_ack_in_fill_cnt", 32'(bus.cnt_o), 32'd0);
    tick();
    bus.ack_i = 1'b0;
    chk("t4_ack_in_fill_ready", 32'(bus.ready_o), 32'd1);

    // 5: reset on the 4th transfer edge
    send(32'h51);
    send(32'h52);
    send(32'h53);
    bus.valid_i = 1'b1;
    bus.data_i  = 32'h54;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.valid_i = 1'b0;
    chk("t5_cnt", 32'(bus.cnt_o), 32'd0);
    chk("t5_fl_end", 32'(bus.fl_end), 32'd0);
    chk("t5_ready", 32'(bus.ready_o), 32'd1);
    chk_frame("t5", 0, 0, 0, 0);

    // 6: continuous stream 0..15 with ack held high
    begin
      int next_w = 0;
      int frames = 0;
      int cyc    = 0;
      int last   = 0;
      logic was_rdy;
      bus.ack_i = 1'b1;
      while (frames < 4 && cyc < 200) begin
        bus.valid_i = (next_w < 16);
        bus.data_i  = 32'(next_w);
        was_rdy     = bus.ready_o;
        tick();
        cyc++;
        if (was_rdy && next_w < 16) next_w++;
        if (bus.fl_end) begin
          for (int i = 0; i < m; i++)
            chk("t6_frame_word", bus.data_o[i], 32'(frames * 4 + i));
          if (frames > 0) chk("t6_period", 32'(cyc - last), 32'd5);
          last = cyc;
          frames++;
        end
      end
      bus.valid_i = 1'b0;
      bus.ack_i   = 1'b0;
      chk("t6_frames", 32'(frames), 32'd4);
      chk("t6_words_sent", 32'(next_w), 32'd16);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
